// File: rtl/ntt_butterfly_sequencer.sv
// rtl/ntt_butterfly_sequencer.sv - NTT/INTT butterfly address and control sequencer
// Optional stall cycle counter output enabled by defining STALL_COUNT_EN.
module ntt_butterfly_sequencer #(
   parameter int LOGN  = 8,
   parameter int DRAIN = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            inv,
   output logic            busy,
   output logic            done,
   output logic            op_valid,
   input  logic            op_ready,
   output logic [LOGN-1:0] op_addr_a,
   output logic [LOGN-1:0] op_addr_b,
   output logic [LOGN-1:0] op_tw_addr,
   output logic            op_sub,
   output logic            op_inv,
   output logic [LOGN-1:0] op_wr_addr,
   output logic [LOGN-1:0] op_stage,
   output logic            op_last
`ifdef STALL_COUNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   localparam int NPTS = 1 << LOGN;
   localparam int DW   = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

   state_t          state, state_nxt;
   logic [LOGN-1:0] j, len, k, stage;
   logic            par, inv_q, fin_q;
   logic [DW-1:0]   dcnt;

   logic [LOGN-1:0] j_inc;
   logic [LOGN:0]   nxt_base;
   logic            group_end, stage_end, xform_end, drain_done, xfer, accept;

   // Groups are aligned to 2*len, so the len bit of j+1 flags the end of a group.
   assign j_inc      = j + 1'b1;
   assign group_end  = |(j_inc & len);
   assign nxt_base   = {1'b0, j} + {1'b0, len} + (LOGN+1)'(1);
   assign stage_end  = group_end & nxt_base[LOGN];
   assign xform_end  = stage_end & (stage == LOGN'(LOGN - 1));
   assign drain_done = (dcnt == DW'(DRAIN));
   assign xfer       = op_valid & op_ready;
   assign accept     = (state == S_IDLE) & start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      op_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            op_valid = 1'b1;
            if (xfer && par && stage_end) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (drain_done) state_nxt = fin_q ? S_FINISH : S_RUN;
         end
         S_FINISH: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         j     <= '0;
         len   <= '0;
         k     <= '0;
         stage <= '0;
         par   <= 1'b0;
         inv_q <= 1'b0;
         fin_q <= 1'b0;
         dcnt  <= '0;
      end else if (accept) begin
         j     <= '0;
         stage <= '0;
         par   <= 1'b0;
         inv_q <= inv;
         fin_q <= 1'b0;
         dcnt  <= '0;
         len   <= inv ? LOGN'(1) : LOGN'(NPTS / 2);
         k     <= inv ? LOGN'(NPTS - 1) : LOGN'(1);
      end else if (state == S_RUN && xfer) begin
         if (!par) begin
            par <= 1'b1;
         end else begin
            par <= 1'b0;
            if (group_end) begin
               // Next group base; wraps to 0 at the end of a stage.
               j <= nxt_base[LOGN-1:0];
               if (!xform_end) k <= inv_q ? k - 1'b1 : k + 1'b1;
            end else begin
               j <= j_inc;
            end
            if (stage_end) begin
               fin_q <= xform_end;
               if (!xform_end) begin
                  stage <= stage + 1'b1;
                  len   <= inv_q ? (len << 1) : (len >> 1);
               end
            end
         end
      end else if (state == S_DRAIN) begin
         dcnt <= drain_done ? '0 : dcnt + 1'b1;
      end
   end

   assign op_addr_a  = j;
   assign op_addr_b  = j + len;
   assign op_tw_addr = k;
   assign op_sub     = par;
   assign op_inv     = inv_q;
   assign op_wr_addr = par ? op_addr_b : op_addr_a;
   assign op_stage   = stage;
   assign op_last    = op_valid & par & xform_end;

`ifdef STALL_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       stall_cnt <= '0;
      else if (accept)               stall_cnt <= '0;
      else if (op_valid && !op_ready) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ntt_butterfly_sequencer.sv
// tb/tb_ntt_butterfly_sequencer.sv - directed bench for ntt_butterfly_sequencer (LOGN=3)
module tb_ntt_butterfly_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, inv = 1'b0, op_ready = 1'b0;
   logic busy, done, op_valid, op_sub, op_inv, op_last;
   logic [2:0] op_addr_a, op_addr_b, op_tw_addr, op_wr_addr, op_stage;

   logic start4 = 1'b0, ready4 = 1'b1;
   logic busy4, done4, valid4, sub4, inv4, last4;
   logic [2:0] a4, b4, tw4, wr4, stg4;
`ifdef STALL_COUNT_EN
   logic [31:0] stall_cnt, stall_cnt4;
`endif

   int checks = 0;
   int errors = 0;

   int fa[12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
   int fb[12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
   int fk[12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
   int ia[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
   int ib[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
   int ik[12] = '{7,6,5,4, 3,3,2,2, 1,1,1,1};

   always #5 clk = ~clk;

   ntt_butterfly_sequencer #(.LOGN(3), .DRAIN(0)) dut (
      .clk(clk), .rst(rst), .start(start), .inv(inv),
      .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
      .op_addr_a(op_addr_a), .op_addr_b(op_addr_b), .op_tw_addr(op_tw_addr),
      .op_sub(op_sub), .op_inv(op_inv), .op_wr_addr(op_wr_addr),
      .op_stage(op_stage), .op_last(op_last)
`ifdef STALL_COUNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   ntt_butterfly_sequencer #(.LOGN(3), .DRAIN(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .inv(1'b0),
      .busy(busy4), .done(done4), .op_valid(valid4), .op_ready(ready4),
      .op_addr_a(a4), .op_addr_b(b4), .op_tw_addr(tw4),
      .op_sub(sub4), .op_inv(inv4), .op_wr_addr(wr4),
      .op_stage(stg4), .op_last(last4)
`ifdef STALL_COUNT_EN
      , .stall_cnt(stall_cnt4)
`endif
   );

   task automatic run_seq(input bit iv, input int low_pct, input int hold, input bit pulse,
                          input string nm);
      int beats, stalls, dones, valids, p;
      bit sb, was_stalled;
      logic [17:0] act, exp_v, held;
      logic [2:0] ea, eb, ek;
      beats = 0; stalls = 0; dones = 0; valids = 0; was_stalled = 0; held = '0;
      @(negedge clk);
      start = 1'b1; inv = iv; op_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || op_valid !== 1'b1)
         begin errors++; $display("FAIL %s_first_valid busy=%b valid=%b want 1 1", nm, busy, op_valid); end
      for (int n = 0; n < 400 && beats < 24; n++) begin
         start = (n < hold - 1) || (pulse && n == 8);
         act = {op_addr_a, op_addr_b, op_tw_addr, op_sub, op_inv, op_wr_addr, op_stage, op_last};
         if (was_stalled) begin
            checks++;
            if (act !== held || op_valid !== 1'b1)
               begin errors++; $display("FAIL %s_stall_hold got %h want %h", nm, act, held); end
         end
         op_ready = ($urandom_range(99) >= low_pct);
         was_stalled = 0;
         if (done) dones++;
         if (op_valid && op_ready) begin
            p  = beats / 2;
            sb = beats[0];
            ea = iv ? 3'(ia[p]) : 3'(fa[p]);
            eb = iv ? 3'(ib[p]) : 3'(fb[p]);
            ek = iv ? 3'(ik[p]) : 3'(fk[p]);
            exp_v = {ea, eb, ek, sb, iv, sb ? eb : ea, 3'(p / 4), 1'(beats == 23)};
            checks++;
            if (act !== exp_v)
               begin errors++; $display("FAIL %s_beat%0d got %h want %h", nm, beats, act, exp_v); end
            beats++;
         end else if (op_valid) begin
            stalls++;
            was_stalled = 1;
            held = act;
         end
         @(negedge clk);
      end
      start = 1'b0;
      op_ready = 1'b1;
      checks++;
      if (beats != 24) begin errors++; $display("FAIL %s_beat_count got %0d want 24", nm, beats); end
      for (int n = 0; n < 40; n++) begin
         if (done) dones++;
         if (op_valid) valids++;
         @(negedge clk);
      end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL %s_done_pulses got %0d want 1", nm, dones); end
      checks++;
      if (valids != 0 || busy !== 1'b0)
         begin errors++; $display("FAIL %s_idle_after got valids=%0d busy=%b want 0 0", nm, valids, busy); end
`ifdef STALL_COUNT_EN
      checks++;
      if (stall_cnt !== 32'(stalls))
         begin errors++; $display("FAIL %s_stall_cnt got %0d want %0d", nm, stall_cnt, stalls); end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, op_valid, op_last, op_addr_a, op_addr_b, op_tw_addr, op_sub, op_inv,
           op_wr_addr, op_stage} !== '0)
         begin errors++; $display("FAIL reset_outputs dut nonzero want all 0"); end
      checks++;
      if ({busy4, done4, valid4, last4, a4, b4, tw4, sub4, inv4, wr4, stg4} !== '0)
         begin errors++; $display("FAIL reset_outputs dut4 nonzero want all 0"); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_forward();
      run_seq(1'b0, 0, 1, 1'b0, "fwd");
   endtask

   task automatic test_inverse();
      run_seq(1'b1, 0, 1, 1'b0, "inv");
   endtask

   task automatic test_random_stall();
      run_seq(1'b0, 40, 1, 1'b0, "stall");
   endtask

   task automatic test_drain();
      int beats, gap, last_n, dones, gaps_seen;
      bit done_chk;
      beats = 0; gap = 0; last_n = 0; dones = 0; gaps_seen = 0; done_chk = 0;
      ready4 = 1'b1;
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (valid4) begin
            if (gap > 0) begin
               gaps_seen++;
               checks++;
               if (gap != 5) begin errors++; $display("FAIL drain_gap got %0d want 5", gap); end
               gap = 0;
            end
            beats++;
            last_n = n;
         end else if (beats > 0 && beats < 24) begin
            gap++;
         end
         if (done4) begin
            dones++;
            if (!done_chk) begin
               done_chk = 1;
               checks++;
               if (n - last_n != 6)
                  begin errors++; $display("FAIL drain_done_delay got %0d want 6", n - last_n); end
            end
         end
         @(negedge clk);
      end
      checks++;
      if (beats != 24 || gaps_seen != 2 || dones != 1)
         begin errors++; $display("FAIL drain_totals got beats=%0d gaps=%0d dones=%0d want 24 2 1",
                                   beats, gaps_seen, dones); end
   endtask

   task automatic test_reset_mid();
      int cnt, dones;
      cnt = 0; dones = 0;
      @(negedge clk); start = 1'b1; inv = 1'b0; op_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 0; n < 50 && cnt < 10; n++) begin
         if (op_valid && op_ready) cnt++;
         if (cnt < 10) @(negedge clk);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, op_valid, op_last, op_addr_a, op_addr_b, op_tw_addr, op_sub, op_inv,
           op_wr_addr, op_stage} !== '0 || cnt != 10)
         begin errors++; $display("FAIL reset_mid_clear got busy=%b valid=%b a=%0d k=%0d beats=%0d want 0 0 0 0 10",
                                   busy, op_valid, op_addr_a, op_tw_addr, cnt); end
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL reset_mid_quiet got %0d want 0", dones); end
      run_seq(1'b0, 0, 1, 1'b0, "restart");
   endtask

   task automatic test_start_ignored();
      run_seq(1'b0, 0, 3, 1'b1, "start_hold");
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_random_stall();
      test_drain();
      test_reset_mid();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
